sim_run_ctrl: RTL and testbench
===============================

Name: sim_run_ctrl

Overview:
- Synthesizable run sequencer that replaces hard-coded delays in the simulation top with cycle-accurate control.
- Holds the CPU in reset for a programmable number of cycles, then counts run cycles.
- Stops on a CPU halt or on a timeout, waits a drain window, then issues per-channel memory-dump requests with a request/acknowledge handshake.
- Sits between the top-level clock/reset and the Cpu instance, driving its active-low reset and its dump_mem strobes.

Parameters:
- RESET_CYCLES, 4: cycles cpu_rstn is held low after launch; minimum 1.
- MAX_CYCLES, 10000: run-cycle timeout; 0 disables the timeout.
- DRAIN_CYCLES, 8: cycles between stop and the first dump request; 0 allowed.
- DUMP_CH, 2: number of dump channels (e.g. imem, dmem, regfile); 1 to 8.
- CNT_W, 32: width of all counters; must satisfy MAX_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  launch pulse; sampled only in IDLE or DONE
- halt  in  1  CPU halted (level or pulse); sampled only in RUN
- cpu_rstn  out  1  active-low reset to CPU, registered
- dump_mem  out  DUMP_CH  one-hot dump request, held until acknowledged
- dump_ack  in  DUMP_CH  per-channel dump completion
- cycle_cnt  out  CNT_W  run cycles elapsed, frozen after RUN
- timeout  out  1  sticky: run ended by timeout
- done  out  1  sticky: all dumps complete

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, cpu_rstn=0, dump_mem=0, cycle_cnt=0, timeout=0, done=0.
  - rst overrides every state, including mid-dump; dump_mem drops at that edge.
- All outputs are registered. States: IDLE, RESET, RUN, DRAIN, DUMP, DONE.
- IDLE:
  - cpu_rstn=0.
  - start=1 → RESET; same edge clears cycle_cnt, timeout, done, and the phase counter.
- RESET:
  - cpu_rstn=0 for exactly RESET_CYCLES cycles, then → RUN.
  - cpu_rstn=1 from the first RUN cycle.
- RUN:
  - cycle_cnt increments every cycle; the first RUN cycle shows 1.
  - halt=1 → DRAIN; the halting cycle is counted.
  - When MAX_CYCLES≠0 and cycle_cnt reaches MAX_CYCLES without halt: → DRAIN with timeout=1 set at the same edge.
  - halt and timeout in the same cycle: halt wins, timeout stays 0.
  - cycle_cnt saturates at all-ones; it never wraps.
- DRAIN:
  - cpu_rstn stays 1; cycle_cnt frozen.
  - Waits DRAIN_CYCLES cycles, then → DUMP with channel index=0.
  - DRAIN_CYCLES=0 goes straight to DUMP on the next edge.
- DUMP:
  - dump_mem[idx]=1, all other bits 0; the request is held until dump_ack[idx]=1.
  - On the ack edge: dump_mem=0 for one cycle, then idx+1 is requested.
  - Ack on the last channel → DONE.
  - dump_ack bits for non-current channels are ignored.
  - An ack already high when a request rises completes that channel in its first cycle.
  - dump_mem is never multi-hot.
- DONE:
  - done=1, cpu_rstn stays 1, dump_mem=0; cycle_cnt and timeout hold.
  - start=1 → RESET, relaunching with all sticky flags cleared.
- start is ignored in RESET, RUN, DRAIN and DUMP. halt is ignored outside RUN.

Optional Feature:
- Macro: SIM_RUN_CTRL_PASSFAIL_EN.
- When defined, adds:
  - input tohost_valid (1 bit), input tohost_data (32 bits), output pass (1 bit), output fail (1 bit).
- In RUN, tohost_valid=1 acts as a halt:
  - data==1 → pass=1.
  - Any other value → fail=1, and tohost_data is latched into the upper bits of an internal code register (debug visible).
- pass and fail are sticky until rst or relaunch.
- A timeout forces fail=1.
- Not defined: ports and logic absent; halt is the only stop source.

Test Plan:
- Basic run: RESET_CYCLES=4; start pulse at cycle 2 → cpu_rstn low through cycle 6, high from cycle 7; halt at the 50th RUN cycle → cycle_cnt=50, timeout=0.
- Timeout: MAX_CYCLES=100, halt never asserted → cycle_cnt=100, timeout=1, then DRAIN, DUMP and done=1.
- Dump handshake: DUMP_CH=3; channel 1 ack delayed 5 cycles → dump_mem sequence 001, 000, 010 (held 5 cycles), 000, 100; done after channel 2 ack; never multi-hot.
- Collision: halt asserted exactly at cycle MAX_CYCLES → timeout=0, cycle_cnt=MAX_CYCLES; start asserted during RUN → ignored.
- Reset mid-dump: rst=1 while dump_mem=010 → next edge dump_mem=0, cpu_rstn=0, state IDLE; a new start → full relaunch with cycle_cnt restarting from 1.
- SIM_RUN_CTRL_PASSFAIL_EN: tohost_data=1 → pass=1; tohost_data=0x15 → fail=1; timeout → fail=1.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl
//
// Cycle-accurate run sequencer for the simulation top. It replaces fixed
// time delays with a small state machine:
//   1. holds the CPU in reset for RESET_CYCLES cycles after a start pulse,
//   2. counts run cycles until the CPU halts or MAX_CYCLES is reached,
//   3. waits DRAIN_CYCLES cycles for in-flight traffic to settle,
//   4. requests a memory dump on each channel in turn, using a
//      request/acknowledge handshake,
//   5. raises a sticky done flag and waits for the next start pulse.
//
// Ports
//   clk        : clock
//   rst        : synchronous active-high reset
//   start      : launch pulse, only accepted while idle or done
//   halt       : CPU halted, only looked at while running
//   cpu_rstn   : registered active-low reset for the CPU
//   dump_mem   : one-hot dump request, held until acknowledged
//   dump_ack   : per-channel dump completion
//   cycle_cnt  : run cycles elapsed, frozen once the run stops
//   timeout    : sticky, the run was ended by the cycle limit
//   done       : sticky, every dump channel has completed
//
// Optional feature (macro SIM_RUN_CTRL_PASSFAIL_EN)
//   tohost_valid / tohost_data : test-result mailbox; a write while running
//                                stops the run like halt does
//   pass / fail                : sticky verdict flags; a timeout is a fail
//   Without the macro these ports and their logic do not exist.

module sim_run_ctrl #(
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 10000,
    parameter int DRAIN_CYCLES = 8,
    parameter int DUMP_CH      = 2,
    parameter int CNT_W        = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt,
    output logic               cpu_rstn,
    output logic [DUMP_CH-1:0] dump_mem,
    input  logic [DUMP_CH-1:0] dump_ack,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               timeout,
    output logic               done
`ifdef SIM_RUN_CTRL_PASSFAIL_EN
    ,
    input  logic               tohost_valid,
    input  logic [31:0]        tohost_data,
    output logic               pass,
    output logic               fail
`endif
);

    localparam int IDX_W = (DUMP_CH > 1) ? $clog2(DUMP_CH) : 1;

    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    // A zero drain length still spends the single DRAIN cycle that follows
    // the stop edge, so both 0 and 1 leave DRAIN after its first cycle.
    localparam logic [CNT_W-1:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? '0 : CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DUMP_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [IDX_W-1:0] idx;
    logic             stop_req;

`ifdef SIM_RUN_CTRL_PASSFAIL_EN
    // Upper 32 bits hold the failing mailbox value, bit 0 marks it as valid.
    logic [32:0] fail_code;
    assign stop_req = halt | tohost_valid;
`else
    assign stop_req = halt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cpu_rstn  <= 1'b0;
            dump_mem  <= '0;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
            done      <= 1'b0;
            phase_cnt <= '0;
            idx       <= '0;
`ifdef SIM_RUN_CTRL_PASSFAIL_EN
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RESET;
                        cpu_rstn  <= 1'b0;
                        dump_mem  <= '0;
                        cycle_cnt <= '0;
                        timeout   <= 1'b0;
                        done      <= 1'b0;
                        phase_cnt <= '0;
`ifdef SIM_RUN_CTRL_PASSFAIL_EN
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        fail_code <= '0;
`endif
                    end
                end

                S_RESET: begin
                    if (phase_cnt == RESET_LAST) begin
                        state     <= S_RUN;
                        cpu_rstn  <= 1'b1;
                        // The first run cycle already counts as cycle 1.
                        cycle_cnt <= CNT_W'(1);
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                S_RUN: begin
                    // The displayed count already includes the current cycle,
                    // so a stop freezes it rather than incrementing it again.
                    // Halt is checked first so it wins over a simultaneous timeout.
                    if (stop_req) begin
                        state     <= S_DRAIN;
                        phase_cnt <= '0;
`ifdef SIM_RUN_CTRL_PASSFAIL_EN
                        if (tohost_valid) begin
                            if (tohost_data == 32'd1) begin
                                pass <= 1'b1;
                            end else begin
                                fail      <= 1'b1;
                                fail_code <= {tohost_data, 1'b1};
                            end
                        end
`endif
                    end else if ((MAX_CYCLES != 0) && (cycle_cnt == MAX_CNT)) begin
                        state     <= S_DRAIN;
                        phase_cnt <= '0;
                        timeout   <= 1'b1;
`ifdef SIM_RUN_CTRL_PASSFAIL_EN
                        fail      <= 1'b1;
`endif
                    end else if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (phase_cnt == DRAIN_LAST) begin
                        state    <= S_DUMP;
                        idx      <= '0;
                        dump_mem <= DUMP_CH'(1);
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                S_DUMP: begin
                    // An empty dump_mem is the one-cycle gap between channels;
                    // acks are only honoured on the channel currently requested.
                    if (dump_mem == '0) begin
                        dump_mem <= DUMP_CH'(1) << idx;
                    end else if ((dump_ack & dump_mem) != '0) begin
                        dump_mem <= '0;
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cpu_rstn <= 1'b0;
                    dump_mem <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl
//
// Self-checking bench for sim_run_ctrl. Each run is described by a halt
// cycle (0 = never halt) and per-channel ack delays; the expected reset
// release time, dump sequence, drain latency, hold lengths and final
// count/timeout are derived from those numbers and queued. A monitor
// watches the DUT outputs and compares each observed event against the
// queue. An ack responder models the memory side with random noise on
// the channels that are not being requested.

module tb_sim_run_ctrl;

    localparam int RESET_CYCLES = 4;
    localparam int MAX_CYCLES   = 100;
    localparam int DRAIN_CYCLES = 3;
    localparam int DUMP_CH      = 3;
    localparam int CNT_W        = 16;
    localparam int RUN_BUDGET   = 600;

    logic               clk;
    logic               rst;
    logic               start;
    logic               halt;
    logic               cpu_rstn;
    logic [DUMP_CH-1:0] dump_mem;
    logic [DUMP_CH-1:0] dump_ack;
    logic [CNT_W-1:0]   cycle_cnt;
    logic               timeout;
    logic               done;
`ifdef SIM_RUN_CTRL_PASSFAIL_EN
    logic               tohost_valid;
    logic [31:0]        tohost_data;
    logic               pass;
    logic               fail;
`endif

    typedef struct {
        int cnt;
        bit tmo;
    } exp_run_t;

    typedef struct {
        logic [DUMP_CH-1:0] mask;
        int                 hold;
        bit                 first;
        int                 lat;
    } exp_dump_t;

    exp_run_t  run_q[$];
    exp_dump_t dump_q[$];
    int        rstn_q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    int ack_delay [DUMP_CH];

    sim_run_ctrl #(
        .RESET_CYCLES(RESET_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .DUMP_CH     (DUMP_CH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .halt     (halt),
        .cpu_rstn (cpu_rstn),
        .dump_mem (dump_mem),
        .dump_ack (dump_ack),
        .cycle_cnt(cycle_cnt),
        .timeout  (timeout),
        .done     (done)
`ifdef SIM_RUN_CTRL_PASSFAIL_EN
        ,
        .tohost_valid(tohost_valid),
        .tohost_data (tohost_data),
        .pass        (pass),
        .fail        (fail)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case a bounded loop is ever defeated.
    initial begin
        forever begin
            @(posedge clk);
            if (cyc > 60000) begin
                $display("[TB] FAIL watchdog: cycle %0d reached, required below 60000", cyc);
                $fatal(1, "[TB] watchdog expired");
            end
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic flushExpectations();
        run_q.delete();
        dump_q.delete();
        rstn_q.delete();
    endtask

    task automatic recoverWithReset();
        mon_en = 1'b0;
        start  = 1'b0;
        halt   = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        flushExpectations();
        mon_en = 1'b1;
        @(posedge clk); #1;
    endtask

    // Memory-side model: acknowledges the active request in its (delay+1)-th
    // cycle and otherwise drives random bits on channels not being requested.
    initial begin
        int cnt;
        int ch;
        dump_ack = '0;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (dump_mem != '0) begin
                cnt++;
                ch = 0;
                for (int i = 0; i < DUMP_CH; i++) begin
                    if (dump_mem[i]) ch = i;
                end
                if (cnt == ack_delay[ch] + 1) dump_ack = dump_mem;
                else dump_ack = DUMP_CH'($urandom) & ~dump_mem;
            end else begin
                cnt = 0;
                dump_ack = DUMP_CH'($urandom);
            end
        end
    end

    // Monitor: compares every observed output event with the queued expectation.
    initial begin
        logic               prev_rstn;
        logic [DUMP_CH-1:0] prev_dump;
        logic               prev_done;
        int                 t_run;
        int                 t_fall;
        int                 hold;
        bit                 multi_hot;
        exp_dump_t          cur;
        exp_run_t           r;
        prev_rstn = 1'b0;
        prev_dump = '0;
        prev_done = 1'b0;
        t_run = 0;
        t_fall = 0;
        hold = 0;
        multi_hot = 1'b0;
        cur = '{mask: '0, hold: 0, first: 1'b0, lat: 0};
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cpu_rstn === 1'b1 && prev_rstn === 1'b0) begin
                    if (rstn_q.size() == 0) begin
                        checkOutput("unexpected_rstn_rise", cyc, -1);
                    end else begin
                        checkOutput("rstn_release_cycle", cyc, rstn_q.pop_front());
                    end
                    checkOutput("first_run_cnt", cycle_cnt, 1);
                    t_run = cyc;
                end
                if (!$onehot0(dump_mem)) multi_hot = 1'b1;
                if (dump_mem != '0 && prev_dump == '0) begin
                    if (dump_q.size() == 0) begin
                        checkOutput("unexpected_dump", dump_mem, 0);
                    end else begin
                        cur = dump_q.pop_front();
                        checkOutput("dump_mask", dump_mem, cur.mask);
                        if (cur.first) checkOutput("drain_latency", cyc - t_run, cur.lat);
                        else checkOutput("dump_gap", cyc - t_fall, 1);
                    end
                    hold = 0;
                end
                if (dump_mem != '0) hold++;
                if (dump_mem == '0 && prev_dump != '0) begin
                    checkOutput("dump_hold", hold, cur.hold);
                    t_fall = cyc;
                end
                if (done === 1'b1 && prev_done === 1'b0) begin
                    if (run_q.size() == 0) begin
                        checkOutput("unexpected_done", done, 0);
                    end else begin
                        r = run_q.pop_front();
                        checkOutput("final_cycle_cnt", cycle_cnt, r.cnt);
                        checkOutput("final_timeout", timeout, r.tmo);
                        checkOutput("done_dump_idle", dump_mem, 0);
                        checkOutput("done_cpu_running", cpu_rstn, 1);
                        checkOutput("dumps_outstanding", dump_q.size(), 0);
                        checkOutput("never_multi_hot", multi_hot, 0);
`ifdef SIM_RUN_CTRL_PASSFAIL_EN
                        checkOutput("fail_flag", fail, r.tmo);
                        checkOutput("pass_flag", pass, 0);
`endif
                    end
                end
            end
            prev_rstn = cpu_rstn;
            prev_dump = dump_mem;
            prev_done = done;
        end
    end

    // One complete launch. h is the run cycle that raises halt (0 = never),
    // d0..d2 the ack delays; rst_mid pulls reset while channel 1 is requested.
    task automatic applyStimulus(input int h, input int d0, input int d1, input int d2, input bit rst_mid);
        int        c;
        int        k;
        int        budget;
        bit        lvl;
        bit        aborted;
        exp_dump_t e;
        exp_run_t  r;
        ack_delay[0] = d0;
        ack_delay[1] = d1;
        ack_delay[2] = d2;
        c = (h >= 1 && h <= MAX_CYCLES) ? h : MAX_CYCLES;
        r.cnt = c;
        r.tmo = (h == 0);
        run_q.push_back(r);
        rstn_q.push_back(cyc + 1 + RESET_CYCLES);
        for (int ch = 0; ch < DUMP_CH; ch++) begin
            e.mask  = DUMP_CH'(1) << ch;
            e.hold  = ack_delay[ch] + 1;
            e.first = (ch == 0);
            e.lat   = c + DRAIN_CYCLES;
            dump_q.push_back(e);
        end

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        // Reset phase: halt and start toggle randomly and must be ignored.
        budget = 0;
        while (cpu_rstn !== 1'b1 && budget < RESET_CYCLES + 4) begin
            halt  = 1'($urandom);
            start = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            budget++;
        end
        checkOutput("reset_exit", cpu_rstn, 1);
        if (cpu_rstn !== 1'b1) begin
            recoverWithReset();
            return;
        end

        lvl = 1'($urandom);
        k = 1;
        budget = 0;
        aborted = 1'b0;
        while (done !== 1'b1 && budget < RUN_BUDGET && !aborted) begin
            if (rst_mid && dump_mem == 3'b010) begin
                mon_en = 1'b0;
                start  = 1'b0;
                halt   = 1'b0;
                rst    = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                checkOutput("midreset_dump_mem", dump_mem, 0);
                checkOutput("midreset_cpu_rstn", cpu_rstn, 0);
                checkOutput("midreset_cycle_cnt", cycle_cnt, 0);
                checkOutput("midreset_done", done, 0);
                flushExpectations();
                mon_en = 1'b1;
                @(posedge clk); #1;
                aborted = 1'b1;
            end else begin
                halt  = (h != 0) && ((k == h) || (lvl && k > h));
                start = ($urandom_range(0, 7) == 0);
                @(posedge clk); #1;
                k++;
                budget++;
            end
        end
        start = 1'b0;
        halt  = 1'b0;
        if (rst_mid) begin
            checkOutput("midreset_taken", aborted, 1);
            if (!aborted) recoverWithReset();
            return;
        end
        checkOutput("run_completes", done, 1);
        if (done !== 1'b1) begin
            recoverWithReset();
            return;
        end
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
    endtask

    initial begin
        int h;
        rst   = 1'b1;
        start = 1'b0;
        halt  = 1'b0;
`ifdef SIM_RUN_CTRL_PASSFAIL_EN
        tohost_valid = 1'b0;
        tohost_data  = 32'd0;
`endif
        for (int i = 0; i < DUMP_CH; i++) ack_delay[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_cpu_rstn", cpu_rstn, 0);
        checkOutput("reset_dump_mem", dump_mem, 0);
        checkOutput("reset_cycle_cnt", cycle_cnt, 0);
        checkOutput("reset_timeout", timeout, 0);
        checkOutput("reset_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_cpu_rstn", cpu_rstn, 0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        $display("[TB] basic run, halt at run cycle 50");
        applyStimulus(50, 1, 2, 0, 1'b0);
        $display("[TB] timeout run, no halt");
        applyStimulus(0, 0, 3, 1, 1'b0);
        $display("[TB] halt exactly at the cycle limit");
        applyStimulus(MAX_CYCLES, 2, 0, 0, 1'b0);
        $display("[TB] halt on first run cycle, channel 1 held 5 cycles");
        applyStimulus(1, 0, 4, 0, 1'b0);
        $display("[TB] reset while channel 1 is requested");
        applyStimulus(20, 0, 30, 0, 1'b1);
        $display("[TB] relaunch from idle after reset");
        applyStimulus(7, 0, 0, 0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            h = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, MAX_CYCLES));
            $display("[TB] random run %0d, halt cycle %0d", n, h);
            applyStimulus(h, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                          int'($urandom_range(0, 6)), 1'b0);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("queues_drained", run_q.size() + dump_q.size() + rstn_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
